// File: rtl/read_sched_pkg.sv
// read_sched_pkg: shared state type and helpers for the read master scheduler
package read_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;
    localparam int WORD_BYTES = 4;
    function automatic logic [63:0] min_bytes(input logic [63:0] a, input logic [63:0] b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/read_master_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last grantee
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_id,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int IW = $clog2(NUM_REQ);
    // Walk the ring from last_id+1 and take the first active requester
    always_comb begin
        logic          found;
        logic [IW-1:0] j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = IW'((int'(last_id) + k) % NUM_REQ);
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end
endmodule

// File: rtl/read_master_scheduler.sv
// read_master_scheduler: shares one read master between requesters, chunking each request
module read_master_scheduler
    import read_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDRESSWIDTH = 32,
    parameter int MAX_CHUNK    = 4096
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_base,
    input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_length,
    input  logic [NUM_REQ-1:0]              req_fixed,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            control_go,
    output logic [ADDRESSWIDTH-1:0]         control_read_base,
    output logic [ADDRESSWIDTH-1:0]         control_read_length,
    output logic                            control_fixed_location,
    input  logic                            control_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int AW = ADDRESSWIDTH;

    state_t             state;
    logic [IW-1:0]      last_id;
    logic [IW-1:0]      idx;
    logic [NUM_REQ-1:0] grant;
    logic [AW-1:0]      cur_addr;
    logic [AW-1:0]      remaining;
    logic [AW-1:0]      sel_base;
    logic [AW-1:0]      sel_len;
    logic [AW-1:0]      nxt_rem;
    logic [AW-1:0]      chunk;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .last_id (last_id),
        .grant   (grant),
        .idx     (idx)
    );

    // Grantee's request with the sub-word length bits dropped; chunk comes from the
    // fresh request when leaving IDLE, otherwise from what is still outstanding
    assign sel_base  = req_base[int'(idx)*AW +: AW];
    assign sel_len   = req_length[int'(idx)*AW +: AW] & ~AW'(WORD_BYTES - 1);
    assign nxt_rem   = (state == IDLE) ? sel_len : remaining;
    assign chunk     = AW'(min_bytes(64'(nxt_rem), 64'(MAX_CHUNK)));
    assign req_ready = (reset_n && state == IDLE) ? grant : '0;

    // Scheduler FSM: accept, issue chunks, wait for the master, report completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            last_id                <= IW'(NUM_REQ - 1);
            grant_id               <= '0;
            busy                   <= 1'b0;
            control_go             <= 1'b0;
            control_read_base      <= '0;
            control_read_length    <= '0;
            control_fixed_location <= 1'b0;
            cur_addr               <= '0;
            remaining              <= '0;
            req_done               <= '0;
        end else begin
            control_go <= 1'b0;
            req_done   <= '0;
            case (state)
                IDLE: if (|req_valid) begin
                    grant_id               <= idx;
                    cur_addr               <= sel_base;
                    remaining              <= sel_len;
                    control_fixed_location <= req_fixed[idx];
                    busy                   <= 1'b1;
                    if (sel_len == '0) begin
                        state    <= FINISH;
                        req_done <= grant;
                    end else begin
                        state               <= ISSUE;
                        control_go          <= 1'b1;
                        control_read_base   <= sel_base;
                        control_read_length <= chunk;
                    end
                end
                ISSUE: begin
                    remaining <= remaining - control_read_length;
                    if (!control_fixed_location)
                        cur_addr <= cur_addr + control_read_length;
                    state <= WAIT;
                end
                WAIT: if (control_done) begin
                    if (remaining != '0) begin
                        state               <= ISSUE;
                        control_go          <= 1'b1;
                        control_read_base   <= cur_addr;
                        control_read_length <= chunk;
                    end else begin
                        state    <= FINISH;
                        req_done <= NUM_REQ'(1) << grant_id;
                    end
                end
                FINISH: begin
                    last_id <= grant_id;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
